// File: rtl/divisor_reconstructor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divisor_reconstructor_pkg
//  Description : Shared constants and state encoding for the shift-add
//                dividend reconstructor (Dividend = Q * Divisor + R).
//  Revision    : 1.0 - initial release
// ============================================================================
package divisor_reconstructor_pkg;

    // Default operand width; the dividend is twice this wide.
    localparam int WIDTH_DEF = 5;

    // Step counter width; must hold WIDTH_DEF-1.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage : divisor_reconstructor_pkg
`default_nettype wire

// File: rtl/divisor_reconstructor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : divisor_reconstructor_ctrl
//  Description : Sequencer for the shift-add reconstructor. Owns the FSM and
//                step counter, and issues load / add / shift / accumulate
//                strobes to the datapath together with the ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module divisor_reconstructor_ctrl
    import divisor_reconstructor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic mplier_lsb_i,
    output logic load_o,
    output logic add_en_o,
    output logic shift_o,
    output logic accum_en_o,
    output logic ready_o
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    // State and step counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and strobe decode; a start seen while busy is simply dropped.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_o     = 1'b0;
        add_en_o   = 1'b0;
        shift_o    = 1'b0;
        accum_en_o = 1'b0;
        ready_o    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    load_o  = 1'b1;
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                shift_o  = 1'b1;
                add_en_o = mplier_lsb_i;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                accum_en_o = 1'b1;
                cnt_d      = '0;
                state_d    = DONE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule : divisor_reconstructor_ctrl
`default_nettype wire

// File: rtl/divisor_reconstructor.sv
`default_nettype none
// ============================================================================
//  Module      : divisor_reconstructor
//  Description : Rebuilds Dividend = Q * Divisor + R with a one-bit-per-clock
//                shift-add multiplier followed by a single remainder add.
//                Also flags R >= Divisor and Divisor == 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module divisor_reconstructor
    import divisor_reconstructor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     Q,
    input  logic [WIDTH-1:0]     Divisor,
    input  logic [WIDTH-1:0]     R,
    output logic [2*WIDTH-1:0]   Dividend,
    output logic                 ready,
    output logic                 RemErr,
    output logic                 DivByZero
);

    logic load, add_en, shift, accum_en;

    logic [WIDTH:0]       acc_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     rem_q;
    logic [2*WIDTH-1:0]   dividend_q;
    logic                 remerr_q;
    logic                 dbz_q;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   dividend_d;

    divisor_reconstructor_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .mplier_lsb_i (mplier_q[0]),
        .load_o       (load),
        .add_en_o     (add_en),
        .shift_o      (shift),
        .accum_en_o   (accum_en),
        .ready_o      (ready)
    );

    // Partial-product add with carry kept, product view, and final remainder add.
    // The top accumulator bit is always zero once all steps are done, so the
    // product fits in 2*WIDTH bits and the remainder add cannot overflow.
    always_comb begin
        sum        = acc_q + (add_en ? {1'b0, mcand_q} : '0);
        prod       = {acc_q[WIDTH-1:0], mplier_q};
        dividend_d = prod + {{WIDTH{1'b0}}, rem_q};
    end

    // Operand capture, shift-add iteration, flag capture and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            mplier_q   <= '0;
            mcand_q    <= '0;
            rem_q      <= '0;
            dividend_q <= '0;
            remerr_q   <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            if (load) begin
                acc_q    <= '0;
                mplier_q <= Q;
                mcand_q  <= Divisor;
                rem_q    <= R;
                remerr_q <= (R >= Divisor);
                dbz_q    <= (Divisor == '0);
            end else if (shift) begin
                acc_q    <= sum >> 1;
                mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
            end
            if (accum_en) begin
                dividend_q <= dividend_d;
            end
        end
    end

    assign Dividend  = dividend_q;
    assign RemErr    = remerr_q;
    assign DivByZero = dbz_q;

endmodule : divisor_reconstructor
`default_nettype wire
